// File: rtl/scarv_cop_palu_ctrl.sv
// Issue/writeback controller for the coprocessor packed ALU.
// Holds one decoded instruction stable while the PALU executes it, then
// holds the PALU result in a write-back register until the CPR file takes
// it. A flush drops the instruction in flight and forces one idle cycle so
// the PALU sees its valid input go low before the next instruction starts.
module scarv_cop_palu_ctrl (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        flush,

    // Decode-stage issue port
    input  logic        id_valid,
    output logic        id_ready,
    input  logic [2:0]  id_class,
    input  logic [3:0]  id_subclass,
    input  logic [2:0]  id_pw,
    input  logic [31:0] id_imm,
    input  logic [3:0]  id_rd,
    input  logic [31:0] id_gpr_rs1,
    input  logic [31:0] id_crs1,
    input  logic [31:0] id_crs2,
    input  logic [31:0] id_crs3,

    // PALU instruction / result port
    output logic        palu_ivalid,
    output logic [2:0]  palu_class,
    output logic [3:0]  palu_subclass,
    output logic [2:0]  palu_pw,
    output logic [31:0] palu_imm,
    output logic [31:0] palu_gpr_rs1,
    output logic [31:0] palu_rs1,
    output logic [31:0] palu_rs2,
    output logic [31:0] palu_rs3,
    input  logic        palu_idone,
    input  logic [3:0]  palu_ben,
    input  logic [31:0] palu_wdata,

    // CPR write port
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [3:0]  wb_rd,
    output logic [3:0]  wb_ben,
    output logic [31:0] wb_wdata,

    // Hazard / status
    output logic        busy_rd_valid,
    output logic [3:0]  busy_rd,
    output logic [7:0]  last_lat
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_WB    = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      state;
    state_t      state_n;

    // Accept strobe for a new instruction; result capture strobe on completion.
    logic        accept;
    logic        capture_res;

    logic [3:0]  rd_q;
    logic [7:0]  exec_cnt;

    // State register.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state, issue acceptance and result capture; flush overrides all.
    always_comb begin
        state_n     = state;
        id_ready    = 1'b0;
        accept      = 1'b0;
        capture_res = 1'b0;
        case (state)
            S_IDLE: begin
                id_ready = 1'b1;
                // A flush in IDLE swallows any same-cycle offer.
                if (!flush && id_valid) begin
                    accept  = 1'b1;
                    state_n = S_EXEC;
                end
            end
            S_EXEC: begin
                if (flush) begin
                    state_n = S_DRAIN;
                end else if (palu_idone) begin
                    capture_res = 1'b1;
                    state_n     = S_WB;
                end
            end
            S_WB: begin
                // Re-accept in the same cycle the result leaves, so a
                // single-cycle op stream runs at one op per two cycles.
                id_ready = wb_ready;
                if (flush) begin
                    state_n = S_DRAIN;
                end else if (wb_ready) begin
                    if (id_valid) begin
                        accept  = 1'b1;
                        state_n = S_EXEC;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Instruction fields and operands: only change on an accepted issue.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            palu_class    <= 3'd0;
            palu_subclass <= 4'd0;
            palu_pw       <= 3'd0;
            palu_imm      <= 32'd0;
            palu_gpr_rs1  <= 32'd0;
            palu_rs1      <= 32'd0;
            palu_rs2      <= 32'd0;
            palu_rs3      <= 32'd0;
            rd_q          <= 4'd0;
        end else if (accept) begin
            palu_class    <= id_class;
            palu_subclass <= id_subclass;
            palu_pw       <= id_pw;
            palu_imm      <= id_imm;
            palu_gpr_rs1  <= id_gpr_rs1;
            palu_rs1      <= id_crs1;
            palu_rs2      <= id_crs2;
            palu_rs3      <= id_crs3;
            rd_q          <= id_rd;
        end
    end

    // EXEC cycle counter (starts at 1) and latency of the last completion.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            exec_cnt <= 8'd0;
            last_lat <= 8'd0;
        end else begin
            if (accept) begin
                exec_cnt <= 8'd1;
            end else if (state == S_EXEC && !flush && !palu_idone &&
                         exec_cnt != 8'hFF) begin
                exec_cnt <= exec_cnt + 8'd1;
            end
            if (capture_res) begin
                last_lat <= exec_cnt;
            end
        end
    end

    // Write-back result register; a zero byte enable is still presented.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            wb_ben   <= 4'd0;
            wb_wdata <= 32'd0;
        end else if (capture_res) begin
            wb_ben   <= palu_ben;
            wb_wdata <= palu_wdata;
        end
    end

    assign palu_ivalid   = (state == S_EXEC);
    assign wb_valid      = (state == S_WB);
    assign busy_rd_valid = (state == S_EXEC) || (state == S_WB);
    assign busy_rd       = rd_q;
    assign wb_rd         = rd_q;

endmodule

// File: tb/tb_scarv_cop_palu_ctrl.sv
// Bench for the PALU issue/writeback controller: directed scenarios with
// literal expectations, then random traffic, all against a transaction model.
module tb_scarv_cop_palu_ctrl;

    logic        g_clk = 1'b0;
    logic        g_resetn, flush, id_valid, id_ready;
    logic [2:0]  id_class, id_pw;
    logic [3:0]  id_subclass, id_rd;
    logic [31:0] id_imm, id_gpr_rs1, id_crs1, id_crs2, id_crs3;
    logic        palu_ivalid;
    logic [2:0]  palu_class, palu_pw;
    logic [3:0]  palu_subclass;
    logic [31:0] palu_imm, palu_gpr_rs1, palu_rs1, palu_rs2, palu_rs3;
    logic        palu_idone;
    logic [3:0]  palu_ben;
    logic [31:0] palu_wdata;
    logic        wb_valid, wb_ready;
    logic [3:0]  wb_rd, wb_ben;
    logic [31:0] wb_wdata;
    logic        busy_rd_valid;
    logic [3:0]  busy_rd;
    logic [7:0]  last_lat;

    int checks = 0;
    int errors = 0;

    scarv_cop_palu_ctrl dut (
        .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready), .id_class(id_class),
        .id_subclass(id_subclass), .id_pw(id_pw), .id_imm(id_imm), .id_rd(id_rd),
        .id_gpr_rs1(id_gpr_rs1), .id_crs1(id_crs1), .id_crs2(id_crs2), .id_crs3(id_crs3),
        .palu_ivalid(palu_ivalid), .palu_class(palu_class), .palu_subclass(palu_subclass),
        .palu_pw(palu_pw), .palu_imm(palu_imm), .palu_gpr_rs1(palu_gpr_rs1),
        .palu_rs1(palu_rs1), .palu_rs2(palu_rs2), .palu_rs3(palu_rs3),
        .palu_idone(palu_idone), .palu_ben(palu_ben), .palu_wdata(palu_wdata),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_ben(wb_ben),
        .wb_wdata(wb_wdata), .busy_rd_valid(busy_rd_valid), .busy_rd(busy_rd),
        .last_lat(last_lat)
    );

    always #5 g_clk = ~g_clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

    // Transaction model: an instruction is either absent, executing, or
    // holding a finished result; a flush leaves one dead cycle behind.
    bit          m_inflight, m_has_result, m_dead;
    int          m_cnt;
    logic [7:0]  m_lat;
    logic [3:0]  m_rd, m_ben;
    logic [31:0] m_wdata;
    logic [2:0]  m_cls, m_pw;
    logic [3:0]  m_sub;
    logic [31:0] m_imm, m_gpr, m_r1, m_r2, m_r3;

    function automatic logic exp_id_ready();
        if (m_dead)       return 1'b0;
        if (!m_inflight)  return 1'b1;
        if (m_has_result) return wb_ready;
        return 1'b0;
    endfunction

    function automatic logic [31:0] padd16(logic [31:0] a, logic [31:0] b);
        logic [15:0] lo, hi;
        lo = a[15:0] + b[15:0];
        hi = a[31:16] + b[31:16];
        return {hi, lo};
    endfunction

    task automatic take_instr();
        m_cls = id_class; m_sub = id_subclass; m_pw = id_pw; m_imm = id_imm;
        m_gpr = id_gpr_rs1; m_r1 = id_crs1; m_r2 = id_crs2; m_r3 = id_crs3;
        m_rd = id_rd; m_inflight = 1; m_has_result = 0; m_cnt = 1;
    endtask

    // Advance the model across one rising edge using the held inputs.
    task automatic model_edge();
        logic rdy;
        rdy = exp_id_ready();
        if (!g_resetn) begin
            m_inflight = 0; m_has_result = 0; m_dead = 0; m_cnt = 0; m_lat = 0;
            m_rd = 0; m_ben = 0; m_wdata = 0; m_cls = 0; m_pw = 0; m_sub = 0;
            m_imm = 0; m_gpr = 0; m_r1 = 0; m_r2 = 0; m_r3 = 0;
        end else if (flush) begin
            m_dead = m_inflight;
            m_inflight = 0; m_has_result = 0;
        end else if (m_dead) begin
            m_dead = 0;
        end else if (!m_inflight) begin
            if (id_valid) take_instr();
        end else if (!m_has_result) begin
            if (palu_idone) begin
                m_ben = palu_ben; m_wdata = palu_wdata; m_lat = 8'(m_cnt);
                m_has_result = 1;
            end else if (m_cnt < 255) begin
                m_cnt++;
            end
        end else if (wb_ready) begin
            if (id_valid && rdy) take_instr();
            else begin m_inflight = 0; m_has_result = 0; end
        end
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Called at a falling edge with inputs set: compare, cross one edge.
    task automatic cycle();
        #1;
        chk("id_ready", id_ready, exp_id_ready());
        chk("palu_ivalid", palu_ivalid, m_inflight && !m_has_result);
        chk("wb_valid", wb_valid, m_has_result);
        chk("busy_rd_valid", busy_rd_valid, m_inflight);
        chk("busy_rd", busy_rd, m_rd);
        chk("wb_rd", wb_rd, m_rd);
        chk("wb_ben", wb_ben, m_ben);
        chk("wb_wdata", wb_wdata, m_wdata);
        chk("last_lat", last_lat, m_lat);
        chk("palu_fields", {palu_class, palu_subclass, palu_pw}, {m_cls, m_sub, m_pw});
        chk("palu_imm", palu_imm, m_imm);
        chk("palu_gpr_rs1", palu_gpr_rs1, m_gpr);
        chk("palu_rs1", palu_rs1, m_r1);
        chk("palu_rs2", palu_rs2, m_r2);
        chk("palu_rs3", palu_rs3, m_r3);
        @(posedge g_clk);
        model_edge();
        @(negedge g_clk);
    endtask

    task automatic set_id(logic [3:0] rd, logic [31:0] r1, logic [31:0] r2);
        id_class = 3'($urandom); id_subclass = 4'($urandom); id_pw = 3'($urandom);
        id_imm = $urandom; id_gpr_rs1 = $urandom; id_crs3 = $urandom;
        id_rd = rd; id_crs1 = r1; id_crs2 = r2;
    endtask

    initial begin
        g_resetn = 0; flush = 0; id_valid = 0; wb_ready = 0;
        palu_idone = 0; palu_ben = 0; palu_wdata = 0;
        set_id(4'd0, 32'd0, 32'd0);
        m_dead = 0; m_inflight = 0; m_has_result = 0;
        @(negedge g_clk);
        @(posedge g_clk); model_edge(); @(negedge g_clk);
        cycle();
        g_resetn = 1;
        #1 chk("rst_id_ready", id_ready, 1); chk("rst_ivalid", palu_ivalid, 0);
        chk("rst_wdata", wb_wdata, 0);
        cycle();

        // Packed 16-bit add, single-cycle.
        set_id(4'd5, 32'h0001_00FF, 32'h0001_0001); id_pw = 3'd1;
        id_valid = 1; wb_ready = 1; cycle();
        id_valid = 0; palu_idone = 1; palu_ben = 4'hF;
        palu_wdata = padd16(32'h0001_00FF, 32'h0001_0001);
        #1 chk("add_ivalid", palu_ivalid, 1); chk("add_nowb", wb_valid, 0);
        cycle();
        palu_idone = 0;
        #1 chk("add_wbv", wb_valid, 1); chk("add_wdata", wb_wdata, 32'h0002_0100);
        chk("add_ben", wb_ben, 4'hF); chk("add_rd", wb_rd, 5); chk("add_lat", last_lat, 1);
        cycle();
        #1 chk("add_idle", wb_valid, 0);

        // Four-cycle multiply; operands must not follow id_* once issued.
        set_id(4'd9, 32'h1234_5678, 32'h0000_0003); id_valid = 1; cycle();
        id_valid = 0; id_crs1 = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            #1 chk("mul_ivalid", palu_ivalid, 1); chk("mul_rs1", palu_rs1, 32'h1234_5678);
            chk("mul_busy", busy_rd_valid, 1);
            cycle();
        end
        palu_idone = 1; palu_wdata = 32'hCAFE_0001; cycle();
        palu_idone = 0;
        #1 chk("mul_wbv", wb_valid, 1); chk("mul_lat", last_lat, 4);
        chk("mul_busy_wb", busy_rd_valid, 1); chk("mul_busy_rd", busy_rd, 9);
        cycle();

        // Untaken cmov (ben=0), write-back stalled with a new offer pending.
        set_id(4'd2, $urandom, 32'h1); id_valid = 1; cycle();
        id_valid = 0; palu_idone = 1; palu_ben = 4'h0; palu_wdata = 32'h11; cycle();
        palu_idone = 0; wb_ready = 0; set_id(4'd7, 32'hA5A5_A5A5, $urandom); id_valid = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("cmov_idr", id_ready, 0); chk("cmov_wbv", wb_valid, 1);
            chk("cmov_ben", wb_ben, 0); chk("cmov_rd", wb_rd, 2);
            cycle();
        end
        wb_ready = 1; cycle();
        id_valid = 0;
        #1 chk("b2b_ivalid", palu_ivalid, 1); chk("b2b_nowb", wb_valid, 0);
        chk("b2b_rs1", palu_rs1, 32'hA5A5_A5A5); chk("b2b_rd", busy_rd, 7);
        palu_idone = 1; palu_ben = 4'hF; cycle();
        palu_idone = 0; cycle();

        // Flush in the second EXEC cycle of a multiply.
        set_id(4'd3, $urandom, $urandom); id_valid = 1; cycle();
        id_valid = 0; cycle();
        flush = 1; palu_idone = 1; cycle();
        flush = 0; palu_idone = 0; id_valid = 1;
        #1 chk("fl_ivalid", palu_ivalid, 0); chk("fl_idr", id_ready, 0);
        chk("fl_wbv", wb_valid, 0); chk("fl_busy", busy_rd_valid, 0); chk("fl_lat", last_lat, 1);
        cycle();
        id_valid = 0;
        #1 chk("fl_idle", id_ready, 1); chk("fl_idle_iv", palu_ivalid, 0);
        cycle();

        // Flush in IDLE swallows the offer.
        flush = 1; id_valid = 1; cycle();
        flush = 0; id_valid = 0;
        #1 chk("fli_ivalid", palu_ivalid, 0);
        cycle();

        // Reset while holding a result.
        set_id(4'd6, $urandom, $urandom); id_valid = 1; cycle();
        id_valid = 0; palu_idone = 1; palu_wdata = 32'h77; cycle();
        palu_idone = 0; wb_ready = 0;
        #1 chk("rwb_wbv", wb_valid, 1);
        g_resetn = 0; cycle();
        g_resetn = 1; wb_ready = 1;
        #1 chk("rwb_wbv0", wb_valid, 0); chk("rwb_idr", id_ready, 1);
        chk("rwb_wdata", wb_wdata, 0); chk("rwb_rd", wb_rd, 0); chk("rwb_lat", last_lat, 0);
        chk("rwb_rs1", palu_rs1, 0); chk("rwb_busy", busy_rd_valid, 0);
        cycle();

        // Latency counter saturation.
        set_id(4'd1, $urandom, $urandom); id_valid = 1; cycle();
        id_valid = 0;
        repeat (299) cycle();
        palu_idone = 1; cycle();
        palu_idone = 0;
        #1 chk("sat_lat", last_lat, 255);
        cycle();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            set_id(4'($urandom), $urandom, $urandom);
            id_valid   = ($urandom_range(0, 1) == 1);
            wb_ready   = ($urandom_range(0, 9) < 6);
            palu_idone = ($urandom_range(0, 9) < 3);
            flush      = ($urandom_range(0, 19) == 0);
            g_resetn   = ($urandom_range(0, 99) != 0);
            palu_ben   = 4'($urandom);
            palu_wdata = $urandom;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scarv_cop_palu_ctrl.md
# scarv_cop_palu_ctrl

Issue/writeback controller for the coprocessor packed ALU (PALU). It accepts one decoded PALU instruction at a time from the decode stage and holds its operands stable while the PALU executes, including multi-cycle packed multiplies. It captures the result on completion and presents it to the CPR write port through a valid/ready handshake. It also exports destination-register busy state for hazard checking and supports a synchronous flush.

## Interface
- No parameters.
- g_clk  in  1  global clock
- g_resetn  in  1  reset, synchronous, active-low
- flush  in  1  abort in-flight instruction
- id_valid  in  1  decode offers instruction
- id_ready  out  1  controller accepts instruction
- id_class / id_subclass / id_pw  in  3/4/3  instruction fields
- id_imm  in  32  immediate
- id_rd  in  4  destination CPR index
- id_gpr_rs1, id_crs1, id_crs2, id_crs3  in  32 each  source operands
- palu_ivalid  out  1  PALU instruction valid
- palu_class / palu_subclass / palu_pw / palu_imm  out  3/4/3/32  registered fields to PALU
- palu_gpr_rs1, palu_rs1, palu_rs2, palu_rs3  out  32 each  registered operands
- palu_idone  in  1  PALU completion
- palu_ben  in  4  PALU writeback byte enable
- palu_wdata  in  32  PALU result
- wb_valid  out  1  result available
- wb_ready  in  1  CPR file accepts
- wb_rd  out  4  destination index
- wb_ben  out  4  byte enable (may be 0, e.g. untaken cmov)
- wb_wdata  out  32  result
- busy_rd_valid  out  1  an instruction is in flight
- busy_rd  out  4  its destination
- last_lat  out  8  EXEC-cycle count of last completed instruction, saturating

## Operation
- States:
  - IDLE: id_ready=1. On id_valid, capture all id_* fields into palu_* registers and id_rd into an rd register, then go to EXEC.
  - EXEC: palu_ivalid=1. Count cycles from 1, saturating at 255. On palu_idone, capture palu_ben/palu_wdata into wb_ben/wb_wdata, load last_lat with the count including the done cycle, and go to WB.
  - WB: wb_valid=1 and id_ready=wb_ready.
    - wb_ready with id_valid: capture the new instruction and go to EXEC (back-to-back).
    - wb_ready without id_valid: go to IDLE.
    - Otherwise hold.
  - DRAIN: one cycle. id_ready=0, palu_ivalid=0. Then go to IDLE.
- A wb_ben of 0 is still presented with wb_valid and consumes the handshake, so completion is always signalled.
- busy_rd_valid=1 in EXEC and WB. busy_rd = captured rd.
- The palu_* operand and field registers change only on an accepted id handshake.
- Flush takes priority over every transition:
  - From EXEC or WB, go to DRAIN. The result is discarded and no wb handshake occurs.
  - From IDLE, stay in IDLE and ignore any same-cycle id_valid.
  - DRAIN guarantees palu_ivalid is low for at least one cycle, so the PALU multiplier restarts cleanly.
- last_lat is not updated on flush.

## Timing
- Reset (synchronous, g_resetn=0 at a rising edge):
  - State goes to IDLE.
  - palu_ivalid=0, wb_valid=0, busy_rd_valid=0.
  - wb_ben=0, wb_wdata=0, wb_rd=0, last_lat=0.
  - All palu_* registers are 0.
  - id_ready=1 from the first cycle after reset.
  - Reset mid-EXEC or mid-WB drops the instruction silently.
- Handshake on id occurs at edge T. palu_ivalid is high from cycle T+1.
- palu_idone is sampled in the same cycle as palu_ivalid. For combinational ops, EXEC lasts 1 cycle and wb_valid rises in cycle T+2.
- For a k-cycle operation, wb_valid rises in cycle T+1+k.
- wb_valid, wb_* and busy_* are registered outputs, stable while wb_ready=0.
- id_ready is combinational from state and wb_ready. palu_ivalid and wb_valid are pure state decodes.
- Peak throughput is one single-cycle op per 2 cycles (EXEC, WB with same-cycle re-accept).

## Test plan
- ADD_PX: rs1=0x0001_00FF, rs2=0x0001_0001, pw=16-bit, rd=5, wb_ready=1 -> wb_valid in cycle T+2 with wdata=0x0002_0100, ben=0xF, rd=5, last_lat=1.
- MUL_PX with palu_idone raised after 4 EXEC cycles -> palu_ivalid held 4 cycles with operands unchanged, wb_valid at T+5, last_lat=4, busy_rd_valid high throughout EXEC and WB.
- CMOV with rs2 nonzero (PALU returns ben=0) -> wb_valid=1, wb_ben=0; controller returns to IDLE only after wb_ready.
- wb_ready held 0 for 3 cycles with id_valid high -> id_ready=0, wb outputs stable. Then wb_ready=1 -> new instruction accepted in the same cycle, palu_ivalid high the next cycle, with no gap into EXEC.
- flush in the 2nd EXEC cycle of a multiply -> next cycle DRAIN (palu_ivalid=0, id_ready=0), then IDLE. No wb_valid, busy_rd_valid=0, last_lat unchanged.
- g_resetn low for one edge while in WB -> wb_valid=0, all outputs at reset values next cycle, id_ready=1.
